// File: rtl/mem_responder.sv
// Memory-side responder: latches a sequencer request, waits WAIT_CYCLES, then reads/writes the internal RAM.
// Define MEM_RDATA_HOLD_EN to keep rdata at the last completed read instead of clearing it after each response.
module mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              addr_strobe,
   input  logic              Wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   state_t            state;
   state_t            next_state;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] ram [DEPTH];
   logic [IDX_W-1:0]  ram_idx;
   logic              addr_ok;
   logic              accept;

   // ready/err/busy are registered, so the ready cycle follows the RESP state;
   // strobes landing in that ready cycle are still part of the response and ignored.
   assign accept  = (state == IDLE) && addr_strobe && !ready;
   assign addr_ok = ({1'b0, req_addr} < DEPTH_LIM);
   assign ram_idx = req_addr[IDX_W-1:0];

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
         WAIT:    if (wait_cnt == 4'd0) next_state = ACCESS;
         ACCESS:  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_wdata <= '0;
         rdata     <= '0;
         ready     <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= next_state;
         ready <= (state == RESP);
         err   <= (state == RESP) && !addr_ok;

         if (accept) begin
            req_addr  <= addr;
            req_we    <= Wr_en;
            req_wdata <= wdata;
            busy      <= 1'b1;
            wait_cnt  <= WAIT_INIT;
         end else begin
            if (state == RESP) busy <= 1'b0;
            if (state == WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
         end

`ifdef MEM_RDATA_HOLD_EN
         if (state == ACCESS && !req_we) rdata <= addr_ok ? ram[ram_idx] : '0;
`else
         // rdata is only meaningful around the response; it drops back to 0 once ready ends.
         if (state == ACCESS && !req_we) rdata <= addr_ok ? ram[ram_idx] : '0;
         else if (ready) rdata <= '0;
`endif
      end
   end

   // An async reset forces IDLE, so an aborted write never reaches this port.
   always_ff @(posedge clk) begin
      if (state == ACCESS && req_we && addr_ok) ram[ram_idx] <= req_wdata;
   end

endmodule
